ssd_readback: RTL and testbench

// Receiving end of the two-digit seven-segment link driven by the display path
// (seg[6:0] + chip_sel time-multiplexing). Samples the multiplexed bus, separates

---
 rtl/ssd_readback_if.sv | 30 +++
 rtl/ssd_readback.sv | 154 +++++++++++++++
 tb/tb_ssd_readback.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_readback_if.sv
// rtl/ssd_readback_if.sv - seven-segment readback bus: sampled link inputs and decoded outputs
//
// seg/chip_sel/sample_en : multiplexed display link as seen by the receiver
// left_val/right_val     : last accepted nibble per digit
// left_ok/right_ok       : held value came from an accepted legal pattern
// upd/err/upd_side       : one-cycle event pulses and the side they refer to
//
// master drives the link and observes results; slave is the receiver.
interface ssd_readback_if;
    logic [6:0] seg;
    logic       chip_sel;
    logic       sample_en;
    logic [3:0] left_val;
    logic [3:0] right_val;
    logic       left_ok;
    logic       right_ok;
    logic       upd;
    logic       upd_side;
    logic       err;

    modport master (
        output seg, chip_sel, sample_en,
        input  left_val, right_val, left_ok, right_ok, upd, upd_side, err
    );

    modport slave (
        input  seg, chip_sel, sample_en,
        output left_val, right_val, left_ok, right_ok, upd, upd_side, err
    );
endinterface

// File: rtl/ssd_readback.sv
// rtl/ssd_readback.sv - two-digit seven-segment link receiver with per-side debounce and hex decode
//
// clk, rst_n : clock, asynchronous active-low reset
// bus        : ssd_readback_if.slave (seg, chip_sel, sample_en in;
//              left/right_val, left/right_ok, upd, upd_side, err out)
//
// Pipeline: stage 0 registers the raw bus, stage 1 debounces per side and
// flags the sample that completes a stable run, stage 2 decodes and updates
// the visible outputs.  Index 1 of every per-side array is the left digit.
module ssd_readback #(
    parameter int STABLE_CNT = 4,
    parameter bit SEG_ACT_LO = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    ssd_readback_if.slave  bus
);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

    // stage 0
    logic [6:0] seg_q, seg_d;
    logic       cs_q, cs_d;
    logic       en_q, en_d;

    // stage 1: debounce state and the acceptance handed to stage 2
    logic [1:0][6:0] cand_q, cand_d;
    logic [1:0][7:0] cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            acc_side_q, acc_side_d;
    logic [6:0]      acc_pat_q, acc_pat_d;

    // stage 2: visible results
    logic [1:0][3:0] val_q, val_d;
    logic [1:0]      ok_q, ok_d;
    logic            upd_q, upd_d;
    logic            err_q, err_d;
    logic            side_q, side_d;

    logic [4:0]      dec;   // {legal, nibble}

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        seg_d      = SEG_ACT_LO ? ~bus.seg : bus.seg;
        cs_d       = bus.chip_sel;
        en_d       = bus.sample_en;

        cand_d     = cand_q;
        cnt_d      = cnt_q;
        acc_d      = 1'b0;
        acc_side_d = cs_q;
        acc_pat_d  = seg_q;

        if (en_q) begin
            if (seg_q == cand_q[cs_q]) begin
                if (cnt_q[cs_q] != CNT_MAX) begin
                    cnt_d[cs_q] = cnt_q[cs_q] + 8'd1;
                end
                // Only the transition into saturation accepts; a saturated
                // count stays put and never re-triggers.
                acc_d = (cnt_q[cs_q] == CNT_MAX - 8'd1);
            end else begin
                cand_d[cs_q] = seg_q;
                cnt_d[cs_q]  = 8'd1;
            end
        end

        val_d  = val_q;
        ok_d   = ok_q;
        upd_d  = 1'b0;
        err_d  = 1'b0;
        side_d = side_q;
        dec    = decode(acc_pat_q);

        if (acc_q) begin
            if (dec[4]) begin
                // Re-accepting the value already held is silent.
                if (!ok_q[acc_side_q] || (dec[3:0] != val_q[acc_side_q])) begin
                    val_d[acc_side_q] = dec[3:0];
                    ok_d[acc_side_q]  = 1'b1;
                    upd_d             = 1'b1;
                    side_d            = acc_side_q;
                end
            end else begin
                // Blank and illegal both invalidate the side; only illegal flags err.
                ok_d[acc_side_q] = 1'b0;
                if (acc_pat_q != 7'h00) begin
                    err_d  = 1'b1;
                    side_d = acc_side_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= 7'h00;
            cs_q       <= 1'b0;
            en_q       <= 1'b0;
            cand_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            acc_side_q <= 1'b0;
            acc_pat_q  <= 7'h00;
            val_q      <= '0;
            ok_q       <= '0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
            side_q     <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            cs_q       <= cs_d;
            en_q       <= en_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_side_q <= acc_side_d;
            acc_pat_q  <= acc_pat_d;
            val_q      <= val_d;
            ok_q       <= ok_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
            side_q     <= side_d;
        end
    end

    assign bus.left_val  = val_q[1];
    assign bus.right_val = val_q[0];
    assign bus.left_ok   = ok_q[1];
    assign bus.right_ok  = ok_q[0];
    assign bus.upd       = upd_q;
    assign bus.err       = err_q;
    assign bus.upd_side  = side_q;
endmodule

// File: tb/tb_ssd_readback.sv
// tb/tb_ssd_readback.sv - randomized and directed check of ssd_readback against a run-length model
module tb_ssd_readback;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_drv = 7'h00;
    logic       cs_drv = 1'b0;
    logic       en_drv = 1'b0;

    always #5 clk = ~clk;

    ssd_readback_if if0 ();
    ssd_readback_if if1 ();

    assign if0.seg       = seg_drv;
    assign if0.chip_sel  = cs_drv;
    assign if0.sample_en = en_drv;
    assign if1.seg       = ~seg_drv;   // active-low instance sees the inverted bus
    assign if1.chip_sel  = cs_drv;
    assign if1.sample_en = en_drv;

    ssd_readback #(.STABLE_CNT(N), .SEG_ACT_LO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    ssd_readback #(.STABLE_CNT(N), .SEG_ACT_LO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per side: length of the current run of identical enabled samples.
    // A run reaching exactly N is an acceptance, seen on the outputs two
    // clocks after the capturing edge.
    logic [6:0] last_pat [2];
    int         run_len  [2];
    logic       ev1_v = 0, ev2_v = 0, ev1_s = 0, ev2_s = 0;
    logic [6:0] ev1_p = 0, ev2_p = 0;
    logic [3:0] exp_val [2];
    logic       exp_ok  [2];
    logic       exp_upd = 0, exp_err = 0, exp_side = 0;

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            last_pat[s] = 7'h00; run_len[s] = 0; exp_val[s] = 4'h0; exp_ok[s] = 1'b0;
        end
        ev1_v = 0; ev2_v = 0; exp_upd = 0; exp_err = 0; exp_side = 0;
    endtask

    task automatic model_apply(input logic v, input logic s, input logic [6:0] p);
        int nib;
        exp_upd = 0;
        exp_err = 0;
        if (!v) return;
        nib = -1;
        for (int i = 0; i < 16; i++) if (tbl[i] == p) nib = i;
        if (nib >= 0) begin
            if (!exp_ok[s] || exp_val[s] != 4'(nib)) begin
                exp_val[s] = 4'(nib); exp_ok[s] = 1; exp_upd = 1; exp_side = s;
            end
        end else if (p == 7'h00) begin
            exp_ok[s] = 0;
        end else begin
            exp_ok[s] = 0; exp_err = 1; exp_side = s;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                model_apply(ev2_v, ev2_s, ev2_p);
                ev2_v = ev1_v; ev2_s = ev1_s; ev2_p = ev1_p;
                ev1_v = 0;
                if (en_drv) begin
                    if (seg_drv == last_pat[cs_drv]) run_len[cs_drv]++;
                    else begin last_pat[cs_drv] = seg_drv; run_len[cs_drv] = 1; end
                    ev1_v = (run_len[cs_drv] == N);
                    ev1_s = cs_drv;
                    ev1_p = seg_drv;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [14:0] obs0, obs1, expv;
    assign obs0 = {if0.left_val, if0.right_val, if0.left_ok, if0.right_ok, if0.upd, if0.upd_side, if0.err};
    assign obs1 = {if1.left_val, if1.right_val, if1.left_ok, if1.right_ok, if1.upd, if1.upd_side, if1.err};
    assign expv = {exp_val[1], exp_val[0], exp_ok[1], exp_ok[0], exp_upd, exp_side, exp_err};

    int   upd_cnt = 0, err_cnt = 0;
    logic upd_sides [$];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("dut0 {lv,rv,lok,rok,upd,side,err}", 32'(obs0), 32'(expv));
            check("dut1 {lv,rv,lok,rok,upd,side,err}", 32'(obs1), 32'(expv));
            if (if0.upd) begin upd_cnt++; upd_sides.push_back(if0.upd_side); end
            if (if0.err) err_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [6:0] p, input logic cs, input logic en);
        @(negedge clk);
        seg_drv = p; cs_drv = cs; en_drv = en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(7'(($urandom)), 1'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; seg_drv = 7'h3F; cs_drv = 1; en_drv = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check("reset outputs dut0", 32'(obs0), 32'h0);
            check("reset outputs dut1", 32'(obs1), 32'h0);
        end
        @(negedge clk);
        en_drv = 0; rst_n = 1;
    endtask

    function automatic logic [6:0] pick();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return tbl[r];
        if (r < 18) return 7'h00;
        return 7'($urandom);
    endfunction

    int         u0, e0;
    logic [14:0] snap;
    logic [6:0] cur [2];
    logic       toggle_mode;

    initial begin
        do_reset();

        // interleaved left/right acceptance
        upd_sides.delete(); u0 = upd_cnt;
        for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 7'h06 : 7'h5B, (i % 2 == 0), 1'b1);
        idle(5);
        check("interleave upd count", 32'(upd_cnt - u0), 32'd2);
        check("interleave first side", 32'(upd_sides[0]), 32'd1);
        check("interleave left_val", 32'(if0.left_val), 32'd1);
        check("interleave right_val", 32'(if0.right_val), 32'd2);
        check("interleave oks", {30'd0, if0.left_ok, if0.right_ok}, 32'd3);
        check("interleave upd_side", 32'(if0.upd_side), 32'd0);

        // interrupted run does not accept
        do_reset();
        u0 = upd_cnt;
        for (int i = 0; i < 3; i++) step(7'h06, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(7'h4F, 1'b1, 1'b1);
        idle(4);
        check("restart left_val", 32'(if0.left_val), 32'd3);
        check("restart upd count", 32'(upd_cnt - u0), 32'd1);

        // blank invalidates but keeps value
        for (int i = 0; i < 4; i++) step(7'h7F, 1'b1, 1'b1);
        idle(4);
        check("eight left_val", 32'(if0.left_val), 32'd8);
        u0 = upd_cnt; e0 = err_cnt;
        for (int i = 0; i < 4; i++) step(7'h00, 1'b1, 1'b1);
        idle(4);
        check("blank left_ok", 32'(if0.left_ok), 32'd0);
        check("blank left_val", 32'(if0.left_val), 32'd8);
        check("blank no events", 32'((upd_cnt - u0) + (err_cnt - e0)), 32'd0);

        // illegal pattern on the right
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) step(7'h01, 1'b0, 1'b1);
        idle(4);
        check("illegal err count", 32'(err_cnt - e0), 32'd1);
        check("illegal upd_side", 32'(if0.upd_side), 32'd0);
        check("illegal right_ok", 32'(if0.right_ok), 32'd0);

        // sample_en low freezes everything
        snap = obs0;
        idle(100);
        check("disabled hold", 32'(obs0), 32'(snap));

        // active-low instance sees 7'h40 and accepts 0
        do_reset();
        for (int i = 0; i < 4; i++) step(7'h3F, 1'b1, 1'b1);
        idle(4);
        check("act_lo left_val", 32'(if1.left_val), 32'd0);
        check("act_lo left_ok", 32'(if1.left_ok), 32'd1);

        // randomized traffic
        cur[0] = pick(); cur[1] = pick(); toggle_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            logic cs;
            if ($urandom_range(0, 199) == 0) toggle_mode = ~toggle_mode;
            cs = toggle_mode ? ~cs_drv : 1'($urandom);
            if ($urandom_range(0, 5) == 0) cur[cs] = pick();
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk); rst_n = 0;
                @(negedge clk); rst_n = 1;
            end
            step(cur[cs], cs, ($urandom_range(0, 9) != 0));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
